// File: rtl/keylock_pkg.sv
// Shared definitions for the keylock digit link (receiver and matching sender).
package keylock_pkg;

    localparam int unsigned DEF_DIGITS  = 6;
    localparam int unsigned DEF_TIMEOUT = 1200000;
    localparam int unsigned SYM_W       = 3;

    // Upper two bits of every HI symbol.
    localparam logic [1:0] HI_MARKER = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_WAIT_LO = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic [1:0] marker;
        logic       lsb;
    } symbol_t;

    // acc * 10 + d in 32-bit wrap-around arithmetic
    function automatic logic [31:0] acc_step(input logic [31:0] acc, input logic [3:0] d);
        return (acc << 3) + (acc << 1) + {28'd0, d};
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer with rising-edge detect; edges are ignored until the
// synchronized line has been seen low after reset.
module edge_sync
    import keylock_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise_c
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic [STAGES-1:0] fill_q, fill_d;
    logic              prev_q, prev_d;
    logic              armed_q, armed_d;
    logic              synced;

    assign synced = sync_q[STAGES-1];

    // fill_q tracks which stages hold a real post-reset sample
    always_comb begin
        sync_d[0] = d;
        fill_d[0] = 1'b1;
        for (int i = 1; i < int'(STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
            fill_d[i] = fill_q[i-1];
        end
        prev_d  = synced;
        armed_d = armed_q | (fill_q[STAGES-1] & ~synced);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fill_q  <= fill_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

    assign rise_c = armed_q & synced & ~prev_q;

endmodule

// File: rtl/digit_receiver.sv
// Receives decimal digits as (LO, HI) 3-bit symbol pairs strobed by controlIn
// and assembles DIGITS-digit frames into a binary number.
module digit_receiver
    import keylock_pkg::*;
#(
    parameter int unsigned DIGITS      = DEF_DIGITS,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        hwclk,
    input  logic        reset,
    input  logic        in0,
    input  logic        in1,
    input  logic        in2,
    input  logic        controlIn,
    output logic [3:0]  digit,
    output logic        digit_valid,
    output logic [31:0] number,
    output logic        number_valid,
    output logic        busy,
    output logic        error
);

    localparam int unsigned CNT_W = $clog2(DIGITS + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    logic [SYNC_STAGES-1:0][SYM_W-1:0] dsync_q, dsync_d;
    logic [SYM_W-1:0] sym_raw;
    symbol_t          sym;
    logic             capture_c;
    logic [3:0]       value;
    logic             abort;

    rx_state_e        state_q, state_d;
    logic [2:0]       lo_q, lo_d;
    logic [31:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             pend_q, pend_d;
    logic [3:0]       digit_q, digit_d;
    logic             digit_valid_q, digit_valid_d;
    logic [31:0]      number_q, number_d;
    logic             number_valid_q, number_valid_d;
    logic             busy_q, busy_d;
    logic             error_q, error_d;

    edge_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ctrl_sync (
        .clk    (hwclk),
        .reset  (reset),
        .d      (controlIn),
        .rise_c (capture_c)
    );

    // Data lines use the same depth so they stay aligned with the strobe.
    always_comb begin
        dsync_d[0] = {in2, in1, in0};
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            dsync_d[i] = dsync_q[i-1];
        end
    end

    assign sym_raw = dsync_q[SYNC_STAGES-1];
    assign sym     = symbol_t'(sym_raw);
    assign value   = {sym.lsb, lo_q};

    always_comb begin
        state_d        = state_q;
        lo_d           = lo_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        pend_d         = 1'b0;
        digit_d        = digit_q;
        digit_valid_d  = 1'b0;
        number_d       = number_q;
        number_valid_d = 1'b0;
        error_d        = 1'b0;
        abort          = 1'b0;
        tmo_d          = (state_q == ST_IDLE) ? '0 : tmo_q + TMO_W'(1);

        // Completed frame publishes one cycle after its last digit.
        if (pend_q) begin
            number_d       = acc_q;
            number_valid_d = 1'b1;
            acc_d          = '0;
            cnt_d          = '0;
        end

        if (capture_c) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE, ST_WAIT_LO: begin
                    lo_d    = sym_raw;
                    state_d = ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (sym.marker != HI_MARKER || value > 4'd9) begin
                        error_d = 1'b1;
                        abort   = 1'b1;
                    end else begin
                        digit_d       = value;
                        digit_valid_d = 1'b1;
                        acc_d         = acc_step(acc_q, value);
                        if (cnt_q == CNT_W'(DIGITS - 1)) begin
                            cnt_d   = '0;
                            pend_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = ST_WAIT_LO;
                        end
                    end
                end
                default: abort = 1'b1;
            endcase
        end else if (state_q != ST_IDLE && tmo_q == TMO_W'(TIMEOUT - 1)) begin
            error_d = 1'b1;
            abort   = 1'b1;
        end

        if (abort) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            tmo_d   = '0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            dsync_q        <= '0;
            state_q        <= ST_IDLE;
            lo_q           <= '0;
            acc_q          <= '0;
            cnt_q          <= '0;
            tmo_q          <= '0;
            pend_q         <= 1'b0;
            digit_q        <= '0;
            digit_valid_q  <= 1'b0;
            number_q       <= '0;
            number_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            dsync_q        <= dsync_d;
            state_q        <= state_d;
            lo_q           <= lo_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            pend_q         <= pend_d;
            digit_q        <= digit_d;
            digit_valid_q  <= digit_valid_d;
            number_q       <= number_d;
            number_valid_q <= number_valid_d;
            busy_q         <= busy_d;
            error_q        <= error_d;
        end
    end

    assign digit        = digit_q;
    assign digit_valid  = digit_valid_q;
    assign number       = number_q;
    assign number_valid = number_valid_q;
    assign busy         = busy_q;
    assign error        = error_q;

endmodule

// File: doc/digit_receiver.md
DIGIT_RECEIVER -- requirements
Module: digit_receiver

Interface
REQ-001 Parameter DIGITS, default 6: decimal digits per number frame.
REQ-002 Parameter TIMEOUT, default 1200000: idle-cycle limit mid-frame (100 ms at 12 MHz).
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth on all four input lines.
REQ-004 hwclk  input  1  12 MHz system clock; sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in0, in1, in2  input  1 each  asynchronous symbol data lines; in0 is the LSB.
REQ-007 controlIn  input  1  asynchronous strobe; a rising edge marks symbol data valid.
REQ-008 digit  output  4  last received decimal digit.
REQ-009 digit_valid  output  1  one-cycle pulse; digit is new.
REQ-010 number  output  32  assembled binary value of the DIGITS-digit frame, zero-extended.
REQ-011 number_valid  output  1  one-cycle pulse; number is new.
REQ-012 busy  output  1  high while a frame is partially received.
REQ-013 error  output  1  one-cycle pulse on framing, range or timeout fault.

Function
REQ-014 Synchronizer: each of in0..in2 and controlIn SHALL pass through SYNC_STAGES flops; symbol capture SHALL occur in the cycle where synced controlIn is 1 and its previous value was 0.
REQ-015 Latency: a controlIn pin rise SHALL be captured exactly SYNC_STAGES+1 cycles later.
REQ-016 Level: controlIn held high SHALL yield exactly one capture.
REQ-017 Digit encoding: a digit is two symbols.
  - LO symbol carries value[2:0].
  - HI symbol carries value[3] on bit0; bits[2:1] SHALL be 2'b00 (marker).
REQ-018 FSM states: IDLE (no frame), WAIT_HI (LO captured), WAIT_LO (count 1..DIGITS-1 digits received).
  - IDLE or WAIT_LO + capture -> WAIT_HI.
  - WAIT_HI + capture, valid digit -> WAIT_LO, or IDLE if this was digit DIGITS.
REQ-019 Valid HI symbol: digit_valid SHALL pulse the cycle after the capture.
REQ-020 Digit accumulation: accumulator = accumulator*10 + digit, 32-bit arithmetic; digit counter increments.
REQ-021 Final digit (count reaches DIGITS):
  - number SHALL load the accumulator value;
  - number_valid SHALL pulse one cycle after that digit_valid;
  - accumulator and counter SHALL clear;
  - FSM SHALL return to IDLE.
REQ-022 number SHALL hold its value until the next number_valid.
REQ-023 digit SHALL hold its value until the next digit_valid.
REQ-024 Marker error: HI symbol bits[2:1] != 00 -> error pulses next cycle; partial frame discarded; FSM returns to IDLE.
REQ-025 Range error: assembled digit > 9 -> error pulse; partial frame discarded; FSM returns to IDLE; no digit_valid.
REQ-026 Timeout counter: clears on every capture; counts only while state != IDLE.
REQ-027 Timeout: counter reaching TIMEOUT-1 -> error pulse; partial frame discarded; FSM returns to IDLE.
REQ-028 Capture and timeout in the same cycle: the capture SHALL win; no error.
REQ-029 busy = (state != IDLE).
REQ-030 digit_valid, number_valid and error SHALL never be high for more than one consecutive cycle.

Reset
REQ-031 Reset SHALL have priority over all other events in the cycle it is asserted.
REQ-032 Reset SHALL force the following, and discard any frame in progress:
  - FSM to IDLE;
  - accumulator, counters and synchronizer flops to 0;
  - digit=0, number=0, and all pulse outputs and busy to 0.
REQ-033 After reset, a controlIn already high SHALL NOT cause a capture until it has been seen low.

Structure
REQ-034 Shared package keylock_pkg SHALL hold:
  - FSM state encoding;
  - HI-symbol marker constant 2'b00;
  - default DIGITS and TIMEOUT.
  The matching sender uses the same package.
REQ-035 Sub-module edge_sync: SYNC_STAGES synchronizer plus rising-edge detector, instantiated once for controlIn; data lines use plain synchronizers of equal depth.

Verification
REQ-036 Send the six digits of 555116, each as a symbol pair (LO, HI), with a 20-cycle spacing between symbols:
  - digit_valid pulses six times with digits 5,5,5,1,1,6;
  - number_valid then pulses with number=0x0008786C;
  - error stays 0.
REQ-037 Send LO=3'b011, then HI=3'b010 -> error pulses; busy drops; no digit_valid.
REQ-038 Send LO=3'b100, then HI=3'b001 (value 12) -> error pulses; no digit_valid; the next full frame is received correctly.
REQ-039 Send 3 digits, then idle for TIMEOUT cycles (TIMEOUT=1000 in the bench) -> exactly one error pulse; busy=0; accumulator cleared.
REQ-040 Assert reset between the LO and HI symbols of digit 4 -> all outputs 0; a subsequent full frame 123456 yields number=0x0001E240.
REQ-041 Hold controlIn high for 100 cycles after one LO symbol -> exactly one capture; busy=1; no digit_valid.
